// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: one outstanding load/store, fixed access latency, valid/ready response.
// Optional range checking of the request address is enabled by YSYX_23060332_DMEM_ADDR_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUSY  | access in flight; latency counter running down
// RESP  | response presented; held until resp_ready
module ysyx_23060332_dmem_resp #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              enter_resp;

    logic              lat_wen;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [NB-1:0]     lat_wmask;

    logic              cur_wen;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [NB-1:0]     cur_wmask;
    logic [31:0]       offset;
    logic [AW-1:0]     idx;
    logic              access_ok;
    logic              unused_bits;

    logic [DATA_W-1:0] mem [DEPTH];

    // With LATENCY==1 the access completes on the accept edge, so the live request is used.
    assign cur_wen   = (state == IDLE) ? req_wen : lat_wen;
    assign cur_addr  = (state == IDLE) ? req_addr : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_wmask = (state == IDLE) ? req_wmask[NB-1:0] : lat_wmask;

    assign offset = cur_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

`ifdef YSYX_23060332_DMEM_ADDR_CHECK_EN
    assign access_ok = ({2'b00, offset[31:2]} < 32'(DEPTH));
`else
    assign access_ok = 1'b1;
`endif

    assign unused_bits = ^{req_wmask, offset};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt_nxt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                lat_wen   <= req_wen;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask[NB-1:0];
            end
            if (enter_resp) begin
                resp_rdata <= (!cur_wen && access_ok) ? mem[idx] : '0;
                resp_err   <= !access_ok;
            end else if (resp_valid && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; a write caught by reset before its commit edge is simply lost.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_wen && access_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (cur_wmask[b]) mem[idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
            end
        end
    end

endmodule
